// File: rtl/slope_lsq_if.sv
// slope_lsq_if: sample/result bundle for slope_lsq
//   clr, read_en, dat_i   : driver -> estimator (sync clear, sample strobe, sample)
//   dat_o, dat_valid_o    : estimator -> driver (scaled slope, full-window pulse)
//   fill_o                : estimator -> driver (window holds N samples)
interface slope_lsq_if #(parameter int R = 15);
  logic clr;
  logic read_en;
  logic signed [R-1:0] dat_i;
  logic signed [R-1:0] dat_o;
  logic dat_valid_o;
  logic fill_o;
  modport master(output clr, read_en, dat_i, input dat_o, dat_valid_o, fill_o);
  modport slave(input clr, read_en, dat_i, output dat_o, dat_valid_o, fill_o);
endinterface

// File: rtl/slope_lsq.sv
// slope_lsq: recursive least-squares slope over a centred 2M+1 window
//   clk, rst : clock, asynchronous active-high reset
//   s        : slope_lsq_if.slave (clr, read_en, dat_i in; dat_o, dat_valid_o, fill_o out)
//   dat_o = (sum k*y[k], k=-M..M) >>> SH, reduced to R bits
//   SLOPE_SAT_EN defined: saturate to R bits; undefined: two's-complement wrap
module slope_lsq #(
  parameter int R  = 15,
  parameter int M  = 4,
  parameter int SH = 0
) (
  input logic clk,
  input logic rst,
  slope_lsq_if.slave s
);
  localparam int N  = 2 * M + 1;
  localparam int SW = R + $clog2(N);
  localparam int WW = R + 2 * $clog2(M + 1) + 1;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [WW-1:0] KM  = WW'(M);
  localparam logic signed [WW-1:0] KM1 = WW'(M + 1);
  logic signed [R-1:0] buf_q [N];
  logic signed [R-1:0] y0, red;
  logic signed [SW-1:0] s_q, s_n;
  logic signed [WW-1:0] w_q, w_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic upd_q, full_q;
`ifdef SLOPE_SAT_EN
  localparam logic signed [WW-1:0] HI = WW'((1 << (R - 1)) - 1);
  localparam logic signed [WW-1:0] LO = ~HI;
  logic signed [WW-1:0] t;
  always_comb begin
    t = w_q >>> SH;
    red = t > HI ? HI[R-1:0] : t < LO ? LO[R-1:0] : t[R-1:0];
  end
`else
  always_comb red = R'(w_q >>> SH);
`endif
  // Recursion stays exact because the window starts zeroed; the
  // intermediate sum may wrap but the final W always fits in WW bits.
  always_comb begin
    y0 = buf_q[0];
    w_n = w_q + KM1 * WW'(y0) - WW'(s_q) + KM * WW'(s.dat_i);
    s_n = s_q - SW'(y0) + SW'(s.dat_i);
    cnt_n = cnt_q == CW'(N) ? cnt_q : cnt_q + 1'b1;
  end
  assign s.fill_o = cnt_q == CW'(N);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
      s_q <= '0;
      w_q <= '0;
      cnt_q <= '0;
      upd_q <= 1'b0;
      full_q <= 1'b0;
      s.dat_o <= '0;
      s.dat_valid_o <= 1'b0;
    end else if (s.clr) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
      s_q <= '0;
      w_q <= '0;
      cnt_q <= '0;
      upd_q <= 1'b0;
      full_q <= 1'b0;
      s.dat_o <= '0;
      s.dat_valid_o <= 1'b0;
    end else begin
      if (s.read_en) begin
        for (int i = 0; i < N - 1; i++) buf_q[i] <= buf_q[i+1];
        buf_q[N-1] <= s.dat_i;
        s_q <= s_n;
        w_q <= w_n;
        cnt_q <= cnt_n;
      end
      upd_q <= s.read_en;
      full_q <= s.read_en && cnt_n == CW'(N);
      if (upd_q) s.dat_o <= red;
      s.dat_valid_o <= upd_q & full_q;
    end
  end
endmodule

// File: tb/tb_slope_lsq.sv
// tb_slope_lsq: scoreboard bench for slope_lsq across M in {4,4(SH=2),1,8,16}
module tb_slope_lsq;
  localparam int ND = 5;
  function automatic int mof(int d);
    return (d == 0 || d == 1) ? 4 : d == 2 ? 1 : d == 3 ? 8 : 16;
  endfunction
  function automatic int shf(int d);
    return d == 1 ? 2 : 0;
  endfunction
  typedef struct {int id; longint val; int cyc;} exp_t;
  logic clk = 0, rst = 0, clr = 0, re = 0;
  logic signed [14:0] din = 0;
  int cyc = 0, errors = 0, checks = 0;
  exp_t q[$];
  longint h[$];
  logic signed [14:0] o [ND];
  logic v [ND];
  logic f [ND];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < ND; g++) begin : u
    slope_lsq_if #(.R(15)) b();
    assign b.clr = clr;
    assign b.read_en = re;
    assign b.dat_i = din;
    assign o[g] = b.dat_o;
    assign v[g] = b.dat_valid_o;
    assign f[g] = b.fill_o;
    slope_lsq #(.R(15), .M(mof(g)), .SH(shf(g))) dut(.clk(clk), .rst(rst), .s(b));
  end
  // Direct-form reference: zero-padded window over the accepted history.
  function automatic longint expv(int m, int sh);
    longint w;
    int n;
    w = 0;
    n = h.size();
    for (int k = -m; k <= m; k++) begin
      int idx;
      idx = n - 1 - (m - k);
      if (idx >= 0) w += k * h[idx];
    end
    w = w >>> sh;
`ifdef SLOPE_SAT_EN
    if (w > 16383) w = 16383;
    else if (w < -16384) w = -16384;
`endif
    return longint'($signed(w[14:0]));
  endfunction
  task automatic chk(string tag, longint got, longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic send(longint x);
    re = 1;
    din = 15'(x);
    h.push_back(x);
    for (int d = 0; d < ND; d++)
      if (h.size() >= 2 * mof(d) + 1) q.push_back('{d, expv(mof(d), shf(d)), cyc + 2});
    @(negedge clk);
    re = 0;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_clr();
    clr = 1;
    @(negedge clk);
    clr = 0;
    re = 0;
    h.delete();
    q.delete();
    chk("clr_fill", f[0], 0);
    chk("clr_dat", o[0], 0);
    chk("clr_valid", v[0], 0);
  endtask
  always @(negedge clk)
    for (int d = 0; d < ND; d++)
      if (v[d] === 1'b1) begin
        int j;
        j = -1;
        for (int i = 0; i < q.size(); i++) if (j < 0 && q[i].id == d) j = i;
        if (j < 0) chk($sformatf("spurious_valid%0d", d), 1, 0);
        else begin
          chk($sformatf("dat%0d", d), o[d], q[j].val);
          chk($sformatf("lat%0d", d), cyc, q[j].cyc);
          q.delete(j);
        end
      end
  initial begin
    #2 rst = 1;
    #1;
    chk("rst_dat", o[0], 0);
    chk("rst_valid", v[0], 0);
    chk("rst_fill", f[0], 0);
    @(negedge clk);
    rst = 0;
    idle(1);
    for (int i = 0; i < 8; i++) send(i);
    chk("fill_before", f[0], 0);
    send(8);
    chk("fill_at9", f[0], 1);
    chk("valid_not_yet", v[0], 0);
    send(9);
    chk("first_valid", v[0], 1);
    chk("first_dat", o[0], 60);
    for (int i = 10; i <= 40; i++) send(i);
    chk("ramp_m4", o[0], 60);
    chk("ramp_sh2", o[1], 15);
    chk("ramp_m1", o[2], 2);
    chk("ramp_m8", o[3], 408);
    chk("ramp_m16", o[4], 2992);
    idle(3);
    do_clr();
    for (int i = 0; i <= 12; i++) begin
      send(i);
      idle($urandom_range(0, 5));
    end
    idle(3);
    do_clr();
    for (int i = 0; i < 9; i++) send(0);
    send(1000);
    send(0);
    chk("impulse_peak", o[0], 4000);
    for (int i = 0; i < 9; i++) send(0);
    for (int i = 0; i < 12; i++) send(1000);
    chk("const_zero", o[0], 0);
    idle(3);
    do_clr();
    for (int i = 0; i <= 8; i++) send(i * 1000);
    idle(1);
`ifdef SLOPE_SAT_EN
    chk("ovf_sat", o[0], 16383);
`else
    chk("ovf_wrap", o[0], -5536);
`endif
    chk("ovf_sh2", o[1], 15000);
    idle(3);
    do_clr();
    for (int i = 1; i <= 5; i++) send(i);
    re = 1;
    din = 99;
    do_clr();
    for (int i = 0; i < 8; i++) send(i);
    idle(2);
    chk("no_valid_8", v[0], 0);
    send(8);
    idle(1);
    chk("valid_after9", v[0], 1);
    chk("dat_after9", o[0], 60);
    send(9);
    idle(1);
    #2 rst = 1;
    #1;
    chk("async_dat", o[0], 0);
    chk("async_valid", v[0], 0);
    chk("async_fill", f[0], 0);
    q.delete();
    h.delete();
    @(negedge clk);
    rst = 0;
    for (int i = 100; i < 109; i++) send(i);
    idle(1);
    chk("post_rst", o[0], 60);
    idle(4);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
